// File: rtl/bextdep_pkg.sv
// Shared types and helpers for the bit-extract/bit-deposit client front end.
package bextdep_pkg;

  localparam int XLEN = 32;

  // Per-operation bookkeeping carried alongside the tag in the in-order FIFO.
  typedef struct packed {
    logic            bypass;
    logic [XLEN-1:0] result;
  } bd_entry_t;

  // All-zero and all-one masks have a trivial answer for both bext and bdep.
  function automatic logic is_bypass(input logic [XLEN-1:0] mask);
    return (mask == '0) || (mask == '1);
  endfunction

  // Empty mask yields zero; full mask passes the operand through unchanged.
  function automatic logic [XLEN-1:0] bypass_result(input logic [XLEN-1:0] value,
                                                    input logic [XLEN-1:0] mask);
    return (mask == '0) ? '0 : value;
  endfunction

endpackage

// File: rtl/bextdep_tag_fifo.sv
// In-order tag FIFO: DEPTH entries of width W, registered storage, head read combinationally.
module bextdep_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bextdep_client.sv
// Initiator-side front end for the bext/bdep unit: forwards work, short-circuits
// trivial masks, and returns tagged results in request order.
module bextdep_client
  import bextdep_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_bdep,
  input  logic [XLEN-1:0]          req_value,
  input  logic [XLEN-1:0]          req_mask,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     unit_din_valid,
  input  logic                     unit_din_ready,
  output logic                     unit_din_bdep,
  output logic [XLEN-1:0]          unit_din_value,
  output logic [XLEN-1:0]          unit_din_mask,
  input  logic                     unit_dout_valid,
  output logic                     unit_dout_ready,
  input  logic [XLEN-1:0]          unit_dout_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_result,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_bypass,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    bd_entry_t        ent;
  } fifo_word_t;

  fifo_word_t push_word;
  fifo_word_t head_word;
  logic       bypass;
  logic       full;
  logic       empty;
  logic       push;
  logic       head_avail;
  logic       load;

  logic             vld_p1;
  logic [XLEN-1:0]  result_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             bypass_p1;

  // Request side: trivial masks never reach the unit.
  assign bypass         = is_bypass(req_mask);
  assign unit_din_valid = req_valid && !bypass && !full;
  assign unit_din_bdep  = req_bdep;
  assign unit_din_value = req_value;
  assign unit_din_mask  = req_mask;
  assign req_ready      = !full && (bypass || unit_din_ready);
  assign push           = req_valid && req_ready;

  assign push_word.tag        = req_tag;
  assign push_word.ent.bypass = bypass;
  assign push_word.ent.result = bypass_result(req_value, req_mask);

  bextdep_tag_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_word_t))
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .pop    (load),
    .din    (push_word),
    .head   (head_word),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Head side: bypass heads are ready at once, unit heads wait for the unit.
  // With nothing outstanding any unit result is stray and is drained.
  assign head_avail      = !empty && (head_word.ent.bypass || unit_dout_valid);
  assign load            = head_avail && (!vld_p1 || rsp_ready);
  assign unit_dout_ready = empty || (!head_word.ent.bypass && load);

  // ---- stage p1: registered response ----
  // Load from the head when the slot is free or being consumed; otherwise hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      tag_p1    <= '0;
      bypass_p1 <= 1'b0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      result_p1 <= head_word.ent.bypass ? head_word.ent.result : unit_dout_result;
      tag_p1    <= head_word.tag;
      bypass_p1 <= head_word.ent.bypass;
    end else if (vld_p1 && rsp_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  // Sticky flag for a unit result that no request is waiting for.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                      err <= 1'b0;
    else if (empty && unit_dout_valid) err <= 1'b1;
  end

  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_tag    = tag_p1;
  assign rsp_bypass = bypass_p1;

endmodule
